// File: rtl/mmio_pkg.sv
// Shared register-map offsets, STATUS bit positions and UART state encoding
// for the memory-mapped UART transmitter.
package mmio_pkg;

    localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
    localparam logic [31:0] TOHOST_OFF = 32'h0000_0008;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_BUSY_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 7;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is still taken
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a write-once
// TOHOST halt register used to end a program run.
//
//   state      | meaning
//   UART_IDLE  | line high, waiting for a queued byte
//   UART_START | start bit (low) for one bit period
//   UART_DATA  | eight data bits, LSB first
//   UART_STOP  | stop bit (high); chains into the next frame if data waits
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        busy
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW          = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] ADDR_TXDATA = BASE_ADDR + TXDATA_OFF;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + STATUS_OFF;
    localparam logic [31:0] ADDR_TOHOST = BASE_ADDR + TOHOST_OFF;

    uart_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_halt;
    logic [31:0]   r_exit;
    logic          r_ovf;
    logic [31:0]   r_rdata;

    logic          w_sel_txdata;
    logic          w_sel_status;
    logic          w_sel_tohost;
    logic          w_push_req;
    logic          w_pop;
    logic          w_baud_end;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_busy;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_val;
    logic          w_unused_addr_lsbs;

    assign w_sel_txdata       = (mem_addr[31:2] == ADDR_TXDATA[31:2]);
    assign w_sel_status       = (mem_addr[31:2] == ADDR_STATUS[31:2]);
    assign w_sel_tohost       = (mem_addr[31:2] == ADDR_TOHOST[31:2]);
    assign w_unused_addr_lsbs = ^mem_addr[1:0];

    assign w_push_req = mem_we && w_sel_txdata;
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_pop      = !w_empty && ((r_state == UART_IDLE) ||
                                     (r_state == UART_STOP && w_baud_end));
    assign w_busy     = (w_count != '0) || (r_state != UART_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_wdata (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                UART_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= UART_START;
                        r_tx    <= 1'b0;
                    end
                end
                UART_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= UART_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                UART_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= UART_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                UART_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        // Chaining straight into START keeps frames gap-free.
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= UART_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= UART_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= UART_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_status                          = '0;
        w_status[STAT_FULL_BIT]           = w_full;
        w_status[STAT_BUSY_BIT]           = w_busy;
        w_status[STAT_OVF_BIT]            = r_ovf;
        w_status[STAT_COUNT_LSB +: CW]    = w_count;
    end

    always_comb begin
        w_rd_val = '0;
        if (w_sel_status) begin
            w_rd_val = w_status;
        end else if (w_sel_tohost) begin
            w_rd_val = r_exit;
        end
    end

    // Reads sample pre-write state, so a same-cycle store is not visible yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_halt  <= 1'b0;
            r_exit  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (mem_we && w_sel_tohost && !r_halt) begin
                r_halt <= 1'b1;
                r_exit <= mem_wdata;
            end
            if (mem_re) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign tx        = r_tx;
    assign halt      = r_halt;
    assign exit_code = r_exit;
    assign mem_rdata = r_rdata;
    assign busy      = w_busy;

endmodule
